// File: rtl/btf_unified_pe_if.sv
// btf_unified_pe_if: per-sample input/result bundle for the unified CT/GS butterfly PE
interface btf_unified_pe_if #(
  parameter int LOGQ = 32,
  parameter int LANES = 2,
  parameter int TAGW = 8
);
  logic in_valid;
  logic in_mode;
  logic [TAGW-1:0] in_tag;
  logic [LANES*LOGQ-1:0] in_a, in_b, in_w;
  logic out_valid;
  logic out_mode;
  logic [TAGW-1:0] out_tag;
  logic [LANES*LOGQ-1:0] out_a, out_b;
  modport master (
    output in_valid, in_mode, in_tag, in_a, in_b, in_w,
    input out_valid, out_mode, out_tag, out_a, out_b
  );
  modport slave (
    input in_valid, in_mode, in_tag, in_a, in_b, in_w,
    output out_valid, out_mode, out_tag, out_a, out_b
  );
endinterface

// File: rtl/btf_unified_pe.sv
// btf_unified_pe: multi-lane CT/GS modular butterfly, constant latency in both modes.
// Define BTF_DIV2_EN to halve GS results mod q (adds one pipeline stage).
module btf_unified_pe #(
  parameter int LOGQ = 32,
  parameter int LANES = 2,
  parameter int TAGW = 8,
  parameter int DELAY_MUL = 4,
  parameter int DELAY_ADD = 1,
`ifdef BTF_DIV2_EN
  localparam int EX = 1,
`else
  localparam int EX = 0,
`endif
  localparam int LAT = DELAY_MUL + DELAY_ADD + EX
) (
  input logic clk,
  input logic rst,
  btf_unified_pe_if.slave io,
  input logic [LOGQ-1:0] q,
  output logic [$clog2(LAT+1)-1:0] inflight,
  output logic busy
);
  localparam int CW = $clog2(LAT+1);
  localparam int SB = LAT - 1;
  localparam int SI = SB - 1 - EX;
  localparam int MD = DELAY_MUL > 1 ? DELAY_MUL - 1 : 1;
  localparam int AD = DELAY_ADD > 1 ? DELAY_ADD - 1 : 1;

  function automatic logic [LOGQ-1:0] add_mod(input logic [LOGQ-1:0] x, y, mq);
    logic [LOGQ:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s >= {1'b0, mq} ? LOGQ'(s - {1'b0, mq}) : s[LOGQ-1:0];
  endfunction

  function automatic logic [LOGQ-1:0] sub_mod(input logic [LOGQ-1:0] x, y, mq);
    return x >= y ? x - y : x - y + mq;
  endfunction

  function automatic logic [LOGQ-1:0] mul_mod(input logic [LOGQ-1:0] x, y, mq);
    logic [2*LOGQ-1:0] p;
    p = {{LOGQ{1'b0}}, x} * {{LOGQ{1'b0}}, y} % {{LOGQ{1'b0}}, mq};
    return p[LOGQ-1:0];
  endfunction

`ifdef BTF_DIV2_EN
  function automatic logic [LOGQ-1:0] half_mod(input logic [LOGQ-1:0] x, mq);
    logic [LOGQ:0] h;
    h = {1'b0, x} + (x[0] ? {1'b0, mq} : '0);
    return h[LOGQ:1];
  endfunction
`endif

  logic [SB-1:0] v, m;
  logic [TAGW-1:0] t [SB];
  logic [LOGQ-1:0] fin_a [LANES], fin_b [LANES];
  logic [CW-1:0] cnt_nx;

  always_ff @(posedge clk) begin
    m[0] <= io.in_mode;
    t[0] <= io.in_tag;
    for (int k = 1; k < SB; k++) begin
      m[k] <= m[k-1];
      t[k] <= t[k-1];
    end
  end

  // Both datapaths run on every sample; the carried mode picks the result at the end.
  for (genvar g = 0; g < LANES; g++) begin : lane
    logic [LOGQ-1:0] a, b, w, ct_x0, ct_y0, gs_y0, sel_a, sel_b;
    logic [LOGQ-1:0] ct_p [DELAY_MUL], ct_a [DELAY_MUL], ct_x [AD], ct_y [AD];
    logic [LOGQ-1:0] gs_s [DELAY_ADD], gs_d [DELAY_ADD], gs_w [DELAY_ADD], gs_x [MD], gs_y [MD];
    assign a = io.in_a[g*LOGQ +: LOGQ];
    assign b = io.in_b[g*LOGQ +: LOGQ];
    assign w = io.in_w[g*LOGQ +: LOGQ];
    always_comb begin
      ct_x0 = add_mod(ct_a[DELAY_MUL-1], ct_p[DELAY_MUL-1], q);
      ct_y0 = sub_mod(ct_a[DELAY_MUL-1], ct_p[DELAY_MUL-1], q);
      gs_y0 = mul_mod(gs_d[DELAY_ADD-1], gs_w[DELAY_ADD-1], q);
      sel_a = m[SI] ? (DELAY_MUL > 1 ? gs_x[MD-1] : gs_s[DELAY_ADD-1])
                    : (DELAY_ADD > 1 ? ct_x[AD-1] : ct_x0);
      sel_b = m[SI] ? (DELAY_MUL > 1 ? gs_y[MD-1] : gs_y0)
                    : (DELAY_ADD > 1 ? ct_y[AD-1] : ct_y0);
    end
    always_ff @(posedge clk) begin
      ct_p[0] <= mul_mod(b, w, q);
      ct_a[0] <= a;
      gs_s[0] <= add_mod(a, b, q);
      gs_d[0] <= sub_mod(a, b, q);
      gs_w[0] <= w;
      ct_x[0] <= ct_x0;
      ct_y[0] <= ct_y0;
      gs_x[0] <= gs_s[DELAY_ADD-1];
      gs_y[0] <= gs_y0;
      for (int k = 1; k < DELAY_MUL; k++) begin
        ct_p[k] <= ct_p[k-1];
        ct_a[k] <= ct_a[k-1];
      end
      for (int k = 1; k < DELAY_ADD; k++) begin
        gs_s[k] <= gs_s[k-1];
        gs_d[k] <= gs_d[k-1];
        gs_w[k] <= gs_w[k-1];
      end
      for (int k = 1; k < AD; k++) begin
        ct_x[k] <= ct_x[k-1];
        ct_y[k] <= ct_y[k-1];
      end
      for (int k = 1; k < MD; k++) begin
        gs_x[k] <= gs_x[k-1];
        gs_y[k] <= gs_y[k-1];
      end
    end
`ifdef BTF_DIV2_EN
    logic [LOGQ-1:0] pa, pb;
    always_ff @(posedge clk) begin
      pa <= sel_a;
      pb <= sel_b;
    end
    assign fin_a[g] = m[SB-1] ? half_mod(pa, q) : pa;
    assign fin_b[g] = m[SB-1] ? half_mod(pb, q) : pb;
`else
    assign fin_a[g] = sel_a;
    assign fin_b[g] = sel_b;
`endif
  end

  assign cnt_nx = inflight + CW'(io.in_valid) - CW'(io.out_valid);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      inflight <= '0;
      busy <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_mode <= 1'b0;
      io.out_tag <= '0;
      io.out_a <= '0;
      io.out_b <= '0;
    end else begin
      v[0] <= io.in_valid;
      for (int k = 1; k < SB; k++) v[k] <= v[k-1];
      inflight <= cnt_nx;
      busy <= cnt_nx != '0;
      io.out_valid <= v[SB-1];
      if (v[SB-1]) begin
        io.out_mode <= m[SB-1];
        io.out_tag <= t[SB-1];
        for (int i = 0; i < LANES; i++) begin
          io.out_a[i*LOGQ +: LOGQ] <= fin_a[i];
          io.out_b[i*LOGQ +: LOGQ] <= fin_b[i];
        end
      end
    end
endmodule

// File: tb/tb_btf_unified_pe.sv
// tb_btf_unified_pe: randomized scoreboard bench for btf_unified_pe against a modular-arithmetic model
module tb_btf_unified_pe;
  localparam int LOGQ = 32;
  localparam int LANES = 4;
  localparam int TAGW = 8;
  localparam int DELAY_MUL = 4;
  localparam int DELAY_ADD = 1;
`ifdef BTF_DIV2_EN
  localparam int LAT = DELAY_MUL + DELAY_ADD + 1;
`else
  localparam int LAT = DELAY_MUL + DELAY_ADD;
`endif
  localparam int LW = LANES * LOGQ;

  typedef struct {
    bit md;
    logic [TAGW-1:0] tg;
    logic [LW-1:0] a, b;
    int cyc;
  } exp_t;

  logic clk, rst;
  logic [LOGQ-1:0] qv;
  logic [$clog2(LAT+1)-1:0] inflight;
  logic busy;
  int cyc, n_chk, n_fail, peak;
  exp_t sb [$];
  logic [LW-1:0] la, lb;
  logic [TAGW-1:0] lt;
  logic lm;

  btf_unified_pe_if #(.LOGQ(LOGQ), .LANES(LANES), .TAGW(TAGW)) io ();

  btf_unified_pe #(.LOGQ(LOGQ), .LANES(LANES), .TAGW(TAGW),
                   .DELAY_MUL(DELAY_MUL), .DELAY_ADD(DELAY_ADD)) dut (
    .clk(clk), .rst(rst), .io(io), .q(qv), .inflight(inflight), .busy(busy));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on 64-bit integers, lane by lane.
  function automatic void ref_model(input bit md, input logic [LW-1:0] a, b, w,
                                    input logic [LOGQ-1:0] qq, output logic [LW-1:0] ea, eb);
    longint unsigned x, y, z, qm, p, ra, rb;
    qm = qq;
    for (int i = 0; i < LANES; i++) begin
      x = a[i*LOGQ +: LOGQ];
      y = b[i*LOGQ +: LOGQ];
      z = w[i*LOGQ +: LOGQ];
      if (!md) begin
        p = (y * z) % qm;
        ra = (x + p) % qm;
        rb = (x + qm - p) % qm;
      end else begin
        ra = (x + y) % qm;
        rb = (((x + qm - y) % qm) * z) % qm;
`ifdef BTF_DIV2_EN
        ra = (ra % 2 == 1) ? (ra + qm) / 2 : ra / 2;
        rb = (rb % 2 == 1) ? (rb + qm) / 2 : rb / 2;
`endif
      end
      ea[i*LOGQ +: LOGQ] = ra[LOGQ-1:0];
      eb[i*LOGQ +: LOGQ] = rb[LOGQ-1:0];
    end
  endfunction

  function automatic logic [LW-1:0] rv(input logic [LOGQ-1:0] qq);
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LOGQ +: LOGQ] = $urandom % qq;
    return r;
  endfunction

  function automatic logic [LW-1:0] rep(input logic [LOGQ-1:0] x);
    return {LANES{x}};
  endfunction

  task automatic issue(input bit vld, input bit md, input logic [TAGW-1:0] tg,
                       input logic [LW-1:0] a, b, w);
    exp_t e;
    @(negedge clk);
    io.in_valid = vld;
    io.in_mode = md;
    io.in_tag = tg;
    io.in_a = a;
    io.in_b = b;
    io.in_w = w;
    e.md = md;
    e.tg = tg;
    e.cyc = cyc + LAT;
    ref_model(md, a, b, w, qv, e.a, e.b);
    @(posedge clk);
    if (vld) sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    issue(0, 0, '0, LW'($urandom), LW'($urandom), LW'($urandom));
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("inflight_idle", LW'(inflight), '0);
  endtask

  // Monitor: occupancy every cycle, results in order with exact timing, data hold between pulses.
  always @(negedge clk) begin
    if (rst) begin
      la = '0;
      lb = '0;
      lt = '0;
      lm = 1'b0;
    end else begin
      chk("inflight", LW'(inflight), LW'(sb.size()));
      chk("busy", LW'(busy), LW'(sb.size() != 0));
      if (int'(inflight) > peak) peak = int'(inflight);
      if (io.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: out_valid=1 tag %0h, expected no result", io.out_tag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_cycle", LW'(cyc), LW'(e.cyc));
          chk("out_mode", LW'(io.out_mode), LW'(e.md));
          chk("out_tag", LW'(io.out_tag), LW'(e.tg));
          chk("out_a", io.out_a, e.a);
          chk("out_b", io.out_b, e.b);
        end
        la = io.out_a;
        lb = io.out_b;
        lt = io.out_tag;
        lm = io.out_mode;
      end else begin
        chk("hold_a", io.out_a, la);
        chk("hold_b", io.out_b, lb);
        chk("hold_tag", LW'(io.out_tag), LW'(lt));
        chk("hold_mode", LW'(io.out_mode), LW'(lm));
      end
    end
  end

  initial begin
    bit [5:0] pat;
    rst = 1;
    qv = 32'd97;
    io.in_valid = 0;
    io.in_mode = 0;
    io.in_tag = '0;
    io.in_a = '0;
    io.in_b = '0;
    io.in_w = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", LW'(io.out_valid), '0);
    chk("rst_out_mode", LW'(io.out_mode), '0);
    chk("rst_out_tag", LW'(io.out_tag), '0);
    chk("rst_out_a", io.out_a, '0);
    chk("rst_out_b", io.out_b, '0);
    chk("rst_inflight", LW'(inflight), '0);
    chk("rst_busy", LW'(busy), '0);
    @(posedge clk);
    #2 rst = 0;

    // Directed small-modulus cases, including odd GS values and q-1 operands.
    issue(1, 0, 8'h11, rep(5), rep(3), rep(4));
    drain();
    issue(1, 1, 8'h22, rep(5), rep(3), rep(4));
    issue(1, 1, 8'h23, rep(4), rep(3), rep(1));
    issue(1, 0, 8'h24, rep(96), rep(96), rep(96));
    issue(1, 1, 8'h25, rep(96), rep(96), rep(96));
    issue(1, 0, 8'h26, rep(0), rep(96), rep(96));
    drain();

    // Gapped valid pattern with garbage data on idle cycles.
    pat = 6'b011001;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 6; i++)
        if (pat[i]) issue(1, 1'($urandom), 8'(r * 8 + i), rv(qv), rv(qv), rv(qv));
        else issue(0, 1'($urandom), 8'hEE, LW'({$urandom, $urandom, $urandom, $urandom}),
                   LW'({$urandom, $urandom, $urandom, $urandom}), LW'({$urandom, $urandom, $urandom, $urandom}));
    drain();

    // Back-to-back alternating CT/GS stream at a large modulus.
    qv = 32'hFFFF_FFFB;
    peak = 0;
    for (int i = 0; i < 200; i++) issue(1, 1'(i % 2), 8'(i), rv(qv), rv(qv), rv(qv));
    drain();
    chk("inflight_peak", LW'(peak), LW'(LAT));
    issue(1, 0, 8'hA0, rep(qv - 1), rep(qv - 1), rep(qv - 1));
    issue(1, 1, 8'hA1, rep(qv - 1), rep(qv - 1), rep(qv - 1));
    issue(1, 1, 8'hA2, rep(0), rep(qv - 1), rep(qv - 1));
    drain();

    // Reset with three samples in flight; none may ever be emitted.
    qv = 32'd97;
    for (int i = 0; i < 3; i++) issue(1, 1'(i % 2), 8'hB0 + 8'(i), rv(qv), rv(qv), rv(qv));
    #1 io.in_valid = 0;
    #1 rst = 1;
    sb.delete();
    #1;
    chk("async_rst_out_valid", LW'(io.out_valid), '0);
    chk("async_rst_inflight", LW'(inflight), '0);
    chk("async_rst_busy", LW'(busy), '0);
    chk("async_rst_out_a", io.out_a, '0);
    chk("async_rst_out_b", io.out_b, '0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    repeat (LAT + 2) @(negedge clk);
    issue(1, 0, 8'hC0, rv(qv), rv(qv), rv(qv));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/btf_unified_pe.md
Name: btf_unified_pe

Overview:
- Multi-lane, runtime-mode butterfly processing element for the SDF NTT pipeline.
- Supersedes the fixed Cooley-Tukey butterfly.
- Each lane performs either a CT (DIT, forward NTT) or a Gentleman-Sande (DIF, inverse NTT) butterfly, selected per sample.
- Latency is constant across modes, so NTT and INTT samples can be interleaved back-to-back. A valid/tag sideband travels with the data, and an occupancy counter reports in-flight samples to the stage controller.

Parameters:
- LOGQ, 32, coefficient/modulus width in bits.
- LANES, 2, number of parallel butterfly lanes sharing one q.
- TAGW, 8, width of the opaque sideband tag carried with each sample.
- DELAY_MUL, 4, modular-multiply latency in cycles, including reduction; must be >= 1.
- DELAY_ADD, 1, modular add/sub latency in cycles; must be >= 1.
- LAT, DELAY_MUL+DELAY_ADD(+1 with BTF_DIV2_EN), derived total latency; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present this cycle.
- in_mode  in  1  0 = CT butterfly, 1 = GS butterfly.
- in_tag  in  TAGW  sideband, returned unchanged with the result.
- in_a  in  LANES*LOGQ  upper inputs; lane i at bits [i*LOGQ +: LOGQ].
- in_b  in  LANES*LOGQ  lower inputs.
- in_w  in  LANES*LOGQ  twiddles.
- q  in  LOGQ  modulus; quasi-static, changed only while busy=0.
- out_valid  out  1  result present.
- out_mode  out  1  mode of the result.
- out_tag  out  TAGW  tag of the result.
- out_a  out  LANES*LOGQ  upper outputs.
- out_b  out  LANES*LOGQ  lower outputs.
- inflight  out  $clog2(LAT+1)  number of samples accepted but not yet emitted.
- busy  out  1  high when inflight != 0.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears every valid stage, inflight, busy, out_valid, out_mode, out_tag, out_a and out_b to 0.
  - Data stages need not be reset.
  - Samples in flight when reset asserts are discarded and never emitted.
- Pipelining: fully pipelined, one sample per cycle, no backpressure.
  - A sample accepted at edge t appears on the outputs with out_valid=1 exactly LAT edges later.
  - out_valid=0 cycles hold the previous out_* data; only out_valid drops.
- Input range: inputs must satisfy a, b, w < q. All outputs are guaranteed < q.
- Modular arithmetic:
  - add: s = a+b computed in LOGQ+1 bits; subtract q if s >= q.
  - sub: d = a-b; add q if a < b.
  - mul: full 2*LOGQ-bit product reduced mod q.
- CT mode (in_mode=0):
  - p = b*w mod q (DELAY_MUL cycles), with a delayed in a matching shift register.
  - out_a = a+p mod q; out_b = a-p mod q (DELAY_ADD cycles).
- GS mode (in_mode=1):
  - s = a+b mod q and d = a-b mod q (DELAY_ADD cycles).
  - out_b = d*w mod q (DELAY_MUL cycles); s is delayed DELAY_MUL cycles to realign with out_b.
  - out_a = s.
- Datapath structure: both datapaths exist physically. A mode bit carried per pipeline stage selects which result is registered at the output, so adjacent samples may differ in mode.
- Lanes are independent and share q; mode and tag are common to all lanes of a sample.
- Occupancy counter:
  - inflight increments on accept, decrements on emit, and is unchanged when both happen in the same cycle.
  - inflight never exceeds LAT; saturating is not required because the pipeline depth bounds it.
  - busy = (inflight != 0), registered.
- Boundary conditions:
  - q change while busy=1: results undefined.
  - a = b = w = q-1 must not overflow any intermediate.
  - in_valid=0: input data is don't-care and must not affect inflight.

Optional Feature:
- Macro BTF_DIV2_EN.
- When defined:
  - GS-mode outputs are halved mod q: x even -> x/2; x odd -> (x+q)/2, computed in LOGQ+1 bits.
  - CT-mode outputs pass through unchanged.
  - One extra register stage is added to both modes, so LAT = DELAY_MUL+DELAY_ADD+1.
- When undefined: no halving, and LAT = DELAY_MUL+DELAY_ADD.

Test Plan:
- CT, q=97, a=5, b=3, w=4, tag=0x11 -> after LAT cycles out_a=17, out_b=90, out_tag=0x11, out_mode=0, out_valid single-cycle pulse.
- GS, q=97, a=5, b=3, w=4 -> out_a=8, out_b=8; with BTF_DIV2_EN -> out_a=4, out_b=4; odd case a=4, b=3, w=1 -> out_a=(7+97)/2=52, out_b=(1+97)/2=49.
- Edge values, CT, q=97, a=b=w=96 -> out_a=0, out_b=95 (b*w mod q = 1).
- Back-to-back stream alternating CT/GS with random per-lane data, LANES=4, 200 samples -> every result matches the reference model in order, with correct tags, exactly LAT cycles after input; inflight peaks at LAT and returns to 0.
- Reset mid-stream: assert rst with 3 samples in flight -> outputs and inflight are 0 immediately (asynchronously); none of the 3 samples is ever emitted; a new sample after reset release emits normally after LAT.
- Gapped input (in_valid pattern 1,0,0,1,1,0) with garbage data on idle cycles -> out_valid reproduces the same pattern delayed by LAT, out data holds between valids, and inflight never counts idle cycles.
